// File: rtl/sdram_burst_writer_pkg.sv
// Shared types and widths for the SDRAM burst writer: burst FSM states and
// the SDRAM address / burst-length field widths.
package sdram_burst_writer_pkg;

    localparam int ADDR_W = 23;
    localparam int LEN_W  = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER
    } state_t;

endpackage

// File: rtl/burst_fifo.sv
// Show-ahead word FIFO: the head word is presented combinationally on o_rdata
// and advances on each pop. A push is accepted when full only if a pop frees a slot.
module burst_fifo #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == LW'(DEPTH));
    assign o_level   = r_level;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Empty FIFO drives zero so the read port is quiet after reset.
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + LW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/sdram_burst_writer.sv
// Buffers 32-bit pixel words and hands them to an SDRAM controller as
// address/length bursts, rewinding to FRAME_BASE at each new frame.
module sdram_burst_writer
    import sdram_burst_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 512,
    parameter int BURST_LEN  = 256,
    parameter int FRAME_BASE = 0
) (
    input  logic              CCD_PIXCLK,
    input  logic              iRst_n,
    input  logic              iFval,
    input  logic [15:0]       wr1_data,
    input  logic [15:0]       wr2_data,
    input  logic              WR_DATA_VAL,
    output logic              oBurstReq,
    output logic [ADDR_W-1:0] oBurstAddr,
    output logic [LEN_W-1:0]  oBurstLen,
    input  logic              iBurstAck,
    input  logic              iRdEn,
    output logic [31:0]       oRdData,
    output logic              oOverflow,
    output logic              oFrameDone
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_fval_d;
    logic              r_eof_pending;
    logic              r_restart_pending;
    logic              r_overflow;

    logic [LVL_W-1:0]  w_level;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_drop;
    logic              w_fval_rise;
    logic              w_fval_fall;
    logic              w_restart_take;
    logic              w_burst_start;
    logic              w_last_pop;
    logic              w_frame_done;
    logic [LEN_W-1:0]  w_len_next;

    burst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .i_clk   (CCD_PIXCLK),
        .i_rst_n (iRst_n),
        .i_push  (WR_DATA_VAL),
        .i_pop   (w_pop),
        .i_wdata ({wr1_data, wr2_data}),
        .o_rdata (oRdData),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop       = (r_state == ST_XFER) && iRdEn && !w_empty;
    assign w_drop      = WR_DATA_VAL && w_full && !w_pop;
    assign w_fval_rise = iFval && !r_fval_d;
    assign w_fval_fall = !iFval && r_fval_d;

    always_comb begin
        w_state_next   = r_state;
        w_restart_take = 1'b0;
        w_burst_start  = 1'b0;
        w_last_pop     = 1'b0;
        w_frame_done   = 1'b0;
        w_len_next     = r_len;
        unique case (r_state)
            ST_IDLE: begin
                // A pending frame restart must rewind the address before any burst.
                if (r_restart_pending) begin
                    w_restart_take = 1'b1;
                end else if (w_level >= LVL_W'(BURST_LEN)) begin
                    w_len_next    = LEN_W'(BURST_LEN);
                    w_burst_start = 1'b1;
                    w_state_next  = ST_REQ;
                end else if (r_eof_pending && (w_level != '0)) begin
                    w_len_next    = LEN_W'(w_level);
                    w_burst_start = 1'b1;
                    w_state_next  = ST_REQ;
                end else if (r_eof_pending) begin
                    w_frame_done = 1'b1;
                end
            end
            ST_REQ: begin
                if (iBurstAck) begin
                    w_state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_pop && (r_remaining == LEN_W'(1))) begin
                    w_last_pop   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CCD_PIXCLK or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state           <= ST_IDLE;
            r_addr            <= ADDR_W'(FRAME_BASE);
            r_len             <= '0;
            r_remaining       <= '0;
            r_fval_d          <= 1'b0;
            r_eof_pending     <= 1'b0;
            r_restart_pending <= 1'b0;
            r_overflow        <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_fval_d <= iFval;
            r_len    <= w_len_next;

            if (w_burst_start) begin
                r_remaining <= w_len_next;
            end else if (w_pop) begin
                r_remaining <= r_remaining - LEN_W'(1);
            end

            if (w_restart_take) begin
                r_addr <= ADDR_W'(FRAME_BASE);
            end else if (w_last_pop) begin
                r_addr <= r_addr + ADDR_W'(r_len);
            end

            // New edges win over same-cycle clears so no frame boundary is lost.
            if (w_restart_take) r_restart_pending <= 1'b0;
            if (w_fval_rise)    r_restart_pending <= 1'b1;
            if (w_frame_done)   r_eof_pending     <= 1'b0;
            if (w_fval_fall)    r_eof_pending     <= 1'b1;
            if (w_fval_rise)    r_overflow        <= 1'b0;
            if (w_drop)         r_overflow        <= 1'b1;
        end
    end

    assign oBurstReq  = (r_state == ST_REQ);
    assign oBurstAddr = r_addr;
    assign oBurstLen  = r_len;
    assign oOverflow  = r_overflow;
    assign oFrameDone = w_frame_done;

endmodule

// File: tb/tb_sdram_burst_writer.sv
// Directed bench for sdram_burst_writer: single burst, frame flush, overflow,
// full-FIFO streaming with mid-burst frame restart, and reset mid-transfer.
module tb_sdram_burst_writer;

    logic        CCD_PIXCLK  = 1'b0;
    logic        iRst_n      = 1'b0;
    logic        iFval       = 1'b0;
    logic [15:0] wr1_data    = '0;
    logic [15:0] wr2_data    = '0;
    logic        WR_DATA_VAL = 1'b0;
    logic        iBurstAck   = 1'b0;
    logic        iRdEn       = 1'b0;
    logic        oBurstReq;
    logic [22:0] oBurstAddr;
    logic [8:0]  oBurstLen;
    logic [31:0] oRdData;
    logic        oOverflow;
    logic        oFrameDone;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CCD_PIXCLK = ~CCD_PIXCLK;

    sdram_burst_writer #(
        .FIFO_DEPTH (512),
        .BURST_LEN  (256),
        .FRAME_BASE (0)
    ) dut (
        .CCD_PIXCLK  (CCD_PIXCLK),
        .iRst_n      (iRst_n),
        .iFval       (iFval),
        .wr1_data    (wr1_data),
        .wr2_data    (wr2_data),
        .WR_DATA_VAL (WR_DATA_VAL),
        .oBurstReq   (oBurstReq),
        .oBurstAddr  (oBurstAddr),
        .oBurstLen   (oBurstLen),
        .iBurstAck   (iBurstAck),
        .iRdEn       (iRdEn),
        .oRdData     (oRdData),
        .oOverflow   (oOverflow),
        .oFrameDone  (oFrameDone)
    );

    function automatic logic [31:0] pix(input int k);
        logic [15:0] h;
        h = 16'(k);
        return {h, h ^ 16'h5A5A};
    endfunction

    task automatic step();
        @(posedge CCD_PIXCLK);
        #1;
    endtask

    task automatic push_words(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            WR_DATA_VAL = 1'b1;
            wr1_data    = 16'(base + k);
            wr2_data    = 16'(base + k) ^ 16'h5A5A;
            step();
        end
        WR_DATA_VAL = 1'b0;
    endtask

    task automatic wait_req();
        for (int n = 0; n < 40 && oBurstReq !== 1'b1; n++) step();
    endtask

    task automatic ack();
        iBurstAck = 1'b1;
        step();
        iBurstAck = 1'b0;
    endtask

    task automatic test_reset();
        iRst_n = 1'b0;
        repeat (3) step();
        n_checks++; if (oBurstReq !== 1'b0)   begin n_errors++; $display("FAIL reset_req: got %0b want 0", oBurstReq); end
        n_checks++; if (oBurstAddr !== 23'd0) begin n_errors++; $display("FAIL reset_addr: got %0d want 0", oBurstAddr); end
        n_checks++; if (oBurstLen !== 9'd0)   begin n_errors++; $display("FAIL reset_len: got %0d want 0", oBurstLen); end
        n_checks++; if (oRdData !== 32'd0)    begin n_errors++; $display("FAIL reset_rdata: got %h want 0", oRdData); end
        n_checks++; if (oOverflow !== 1'b0)   begin n_errors++; $display("FAIL reset_ovf: got %0b want 0", oOverflow); end
        n_checks++; if (oFrameDone !== 1'b0)  begin n_errors++; $display("FAIL reset_done: got %0b want 0", oFrameDone); end
        iRst_n = 1'b1;
        step();
        $display("reset released");
    endtask

    task automatic test_single_burst();
        push_words(0, 1);
        n_checks++; if (oRdData !== pix(0)) begin n_errors++; $display("FAIL showahead: got %h want %h", oRdData, pix(0)); end
        push_words(1, 255);
        wait_req();
        n_checks++; if (oBurstReq !== 1'b1)    begin n_errors++; $display("FAIL b1_req: got %0b want 1", oBurstReq); end
        n_checks++; if (oBurstAddr !== 23'd0)  begin n_errors++; $display("FAIL b1_addr: got %0d want 0", oBurstAddr); end
        n_checks++; if (oBurstLen !== 9'd256)  begin n_errors++; $display("FAIL b1_len: got %0d want 256", oBurstLen); end
        $display("burst addr=%0d len=%0d", oBurstAddr, oBurstLen);
        ack();
        n_checks++; if (oBurstReq !== 1'b0) begin n_errors++; $display("FAIL b1_req_drop: got %0b want 0", oBurstReq); end
        for (int k = 0; k < 256; k++) begin
            iRdEn = 1'b1;
            n_checks++; if (oRdData !== pix(k)) begin n_errors++; $display("FAIL b1_data[%0d]: got %h want %h", k, oRdData, pix(k)); end
            step();
        end
        iRdEn = 1'b0;
        n_checks++; if (oBurstAddr !== 23'd256) begin n_errors++; $display("FAIL b1_addr_after: got %0d want 256", oBurstAddr); end
        n_checks++; if (oFrameDone !== 1'b0)    begin n_errors++; $display("FAIL b1_done: got %0b want 0", oFrameDone); end
        step();
        n_checks++; if (oBurstReq !== 1'b0) begin n_errors++; $display("FAIL b1_no_extra_req: got %0b want 0", oBurstReq); end
    endtask

    task automatic test_frame_flush();
        iFval = 1'b1;
        push_words(1000, 300);
        iFval = 1'b0;
        step();
        wait_req();
        n_checks++; if (oBurstReq !== 1'b1)   begin n_errors++; $display("FAIL f1_req: got %0b want 1", oBurstReq); end
        n_checks++; if (oBurstAddr !== 23'd0) begin n_errors++; $display("FAIL f1_addr: got %0d want 0", oBurstAddr); end
        n_checks++; if (oBurstLen !== 9'd256) begin n_errors++; $display("FAIL f1_len: got %0d want 256", oBurstLen); end
        $display("burst addr=%0d len=%0d", oBurstAddr, oBurstLen);
        ack();
        for (int k = 0; k < 256; k++) begin
            iRdEn = 1'b1;
            n_checks++; if (oRdData !== pix(1000 + k)) begin n_errors++; $display("FAIL f1_data[%0d]: got %h want %h", k, oRdData, pix(1000 + k)); end
            step();
        end
        iRdEn = 1'b0;
        wait_req();
        n_checks++; if (oBurstReq !== 1'b1)     begin n_errors++; $display("FAIL f2_req: got %0b want 1", oBurstReq); end
        n_checks++; if (oBurstAddr !== 23'd256) begin n_errors++; $display("FAIL f2_addr: got %0d want 256", oBurstAddr); end
        n_checks++; if (oBurstLen !== 9'd44)    begin n_errors++; $display("FAIL f2_len: got %0d want 44", oBurstLen); end
        $display("burst addr=%0d len=%0d", oBurstAddr, oBurstLen);
        ack();
        for (int k = 0; k < 44; k++) begin
            iRdEn = 1'b1;
            n_checks++; if (oRdData !== pix(1256 + k)) begin n_errors++; $display("FAIL f2_data[%0d]: got %h want %h", k, oRdData, pix(1256 + k)); end
            step();
        end
        iRdEn = 1'b0;
        n_checks++; if (oFrameDone !== 1'b1) begin n_errors++; $display("FAIL frame_done: got %0b want 1", oFrameDone); end
        step();
        n_checks++; if (oFrameDone !== 1'b0) begin n_errors++; $display("FAIL frame_done_pulse: got %0b want 0", oFrameDone); end
        $display("frame done");
    endtask

    task automatic test_overflow();
        iFval = 1'b1;
        push_words(2000, 520);
        n_checks++; if (oOverflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set: got %0b want 1", oOverflow); end
        wait_req();
        n_checks++; if (oBurstAddr !== 23'd0) begin n_errors++; $display("FAIL o1_addr: got %0d want 0", oBurstAddr); end
        n_checks++; if (oBurstLen !== 9'd256) begin n_errors++; $display("FAIL o1_len: got %0d want 256", oBurstLen); end
        $display("burst addr=%0d len=%0d overflow=%0b", oBurstAddr, oBurstLen, oOverflow);
        ack();
        n_checks++; if (oRdData !== pix(2000)) begin n_errors++; $display("FAIL o1_head: got %h want %h", oRdData, pix(2000)); end
        iFval = 1'b0;
        step();
        iFval = 1'b1;
        step();
        n_checks++; if (oOverflow !== 1'b0)   begin n_errors++; $display("FAIL ovf_clear: got %0b want 0", oOverflow); end
        n_checks++; if (oBurstAddr !== 23'd0) begin n_errors++; $display("FAIL xfer_addr_hold: got %0d want 0", oBurstAddr); end
        n_checks++; if (oBurstReq !== 1'b0)   begin n_errors++; $display("FAIL xfer_req_hold: got %0b want 0", oBurstReq); end
    endtask

    task automatic test_push_pop_full();
        for (int k = 0; k < 20; k++) begin
            WR_DATA_VAL = 1'b1;
            wr1_data    = 16'(3000 + k);
            wr2_data    = 16'(3000 + k) ^ 16'h5A5A;
            iRdEn       = 1'b1;
            n_checks++; if (oRdData !== pix(2000 + k)) begin n_errors++; $display("FAIL pp_data[%0d]: got %h want %h", k, oRdData, pix(2000 + k)); end
            step();
        end
        WR_DATA_VAL = 1'b0;
        n_checks++; if (oOverflow !== 1'b0) begin n_errors++; $display("FAIL pp_no_ovf: got %0b want 0", oOverflow); end
        for (int k = 0; k < 236; k++) begin
            iRdEn = 1'b1;
            n_checks++; if (oRdData !== pix(2020 + k)) begin n_errors++; $display("FAIL pp_tail[%0d]: got %h want %h", k, oRdData, pix(2020 + k)); end
            step();
        end
        iRdEn = 1'b0;
        n_checks++; if (oBurstAddr !== 23'd256) begin n_errors++; $display("FAIL pp_addr_after: got %0d want 256", oBurstAddr); end
        wait_req();
        n_checks++; if (oBurstAddr !== 23'd0) begin n_errors++; $display("FAIL restart_addr: got %0d want 0", oBurstAddr); end
        n_checks++; if (oBurstLen !== 9'd256) begin n_errors++; $display("FAIL restart_len: got %0d want 256", oBurstLen); end
        $display("burst addr=%0d len=%0d", oBurstAddr, oBurstLen);
        ack();
        for (int k = 0; k < 256; k++) begin
            iRdEn = 1'b1;
            n_checks++; if (oRdData !== pix(2256 + k)) begin n_errors++; $display("FAIL r1_data[%0d]: got %h want %h", k, oRdData, pix(2256 + k)); end
            step();
        end
        iRdEn = 1'b0;
        wait_req();
        n_checks++; if (oBurstAddr !== 23'd256) begin n_errors++; $display("FAIL r2_addr: got %0d want 256", oBurstAddr); end
        n_checks++; if (oBurstLen !== 9'd20)    begin n_errors++; $display("FAIL r2_len: got %0d want 20", oBurstLen); end
        $display("burst addr=%0d len=%0d", oBurstAddr, oBurstLen);
        ack();
        for (int k = 0; k < 20; k++) begin
            iRdEn = 1'b1;
            n_checks++; if (oRdData !== pix(3000 + k)) begin n_errors++; $display("FAIL r2_data[%0d]: got %h want %h", k, oRdData, pix(3000 + k)); end
            step();
        end
        iRdEn = 1'b0;
        n_checks++; if (oFrameDone !== 1'b1) begin n_errors++; $display("FAIL r2_done: got %0b want 1", oFrameDone); end
        step();
    endtask

    task automatic test_reset_mid_xfer();
        push_words(4000, 256);
        wait_req();
        n_checks++; if (oBurstAddr !== 23'd276) begin n_errors++; $display("FAIL m_addr: got %0d want 276", oBurstAddr); end
        n_checks++; if (oBurstLen !== 9'd256)   begin n_errors++; $display("FAIL m_len: got %0d want 256", oBurstLen); end
        $display("burst addr=%0d len=%0d", oBurstAddr, oBurstLen);
        ack();
        for (int k = 0; k < 10; k++) begin
            iRdEn = 1'b1;
            n_checks++; if (oRdData !== pix(4000 + k)) begin n_errors++; $display("FAIL m_data[%0d]: got %h want %h", k, oRdData, pix(4000 + k)); end
            step();
        end
        iRdEn = 1'b0;
        iFval = 1'b0;
        step();
        iRst_n = 1'b0;
        #1;
        n_checks++; if (oBurstReq !== 1'b0)   begin n_errors++; $display("FAIL mr_req: got %0b want 0", oBurstReq); end
        n_checks++; if (oBurstAddr !== 23'd0) begin n_errors++; $display("FAIL mr_addr: got %0d want 0", oBurstAddr); end
        n_checks++; if (oBurstLen !== 9'd0)   begin n_errors++; $display("FAIL mr_len: got %0d want 0", oBurstLen); end
        n_checks++; if (oRdData !== 32'd0)    begin n_errors++; $display("FAIL mr_rdata: got %h want 0", oRdData); end
        n_checks++; if (oFrameDone !== 1'b0)  begin n_errors++; $display("FAIL mr_done: got %0b want 0", oFrameDone); end
        step();
        step();
        iRst_n = 1'b1;
        $display("reset asserted mid-transfer");
        for (int k = 0; k < 10; k++) begin
            step();
            n_checks++; if (oFrameDone !== 1'b0) begin n_errors++; $display("FAIL post_reset_done[%0d]: got %0b want 0", k, oFrameDone); end
            n_checks++; if (oBurstReq !== 1'b0)  begin n_errors++; $display("FAIL post_reset_req[%0d]: got %0b want 0", k, oBurstReq); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_burst();
        test_frame_flush();
        test_overflow();
        test_push_pop_full();
        test_reset_mid_xfer();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
